// File: rtl/mem_wb_stage.sv
// mem_wb_stage: EX/MEM and MEM/WB pipeline registers, data memory and forwarding selects.
// Define OV_TRAP_EN to squash overflowing instructions and raise the sticky OvFlag.
module mem_wb_stage #(
   parameter int DATA_WIDTH     = 8,
   parameter int REG_DIR_WIDTH  = 3,
   parameter int MEM_ADDR_WIDTH = 5
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [DATA_WIDTH-1:0]    ALUResult,
   input  logic [DATA_WIDTH-1:0]    StoreData,
   input  logic [REG_DIR_WIDTH-1:0] WriteReg,
   input  logic                     Ov,
   input  logic                     RegWrite,
   input  logic                     MemRead,
   input  logic                     MemWrite,
   input  logic                     MemtoReg,
   input  logic [REG_DIR_WIDTH-1:0] Rs,
   input  logic [REG_DIR_WIDTH-1:0] Rt,
   input  logic                     stall,
   input  logic                     flush,
   output logic [DATA_WIDTH-1:0]    Address,
   output logic [DATA_WIDTH-1:0]    WBData,
   output logic [REG_DIR_WIDTH-1:0] WBReg,
   output logic                     WBRegWrite,
   output logic [1:0]               Forward_A,
   output logic [1:0]               Forward_B,
   output logic                     OvFlag
);

   localparam int DEPTH = 1 << MEM_ADDR_WIDTH;

   logic [DATA_WIDTH-1:0]     exm_store;
   logic [REG_DIR_WIDTH-1:0]  exm_reg;
   logic                      exm_regwrite;
   logic                      exm_memread;
   logic                      exm_memwrite;
   logic                      exm_memtoreg;
   logic [DATA_WIDTH-1:0]     mem [DEPTH];
   logic [MEM_ADDR_WIDTH-1:0] mem_idx;
   logic [DATA_WIDTH-1:0]     mem_rdata;
   logic                      trap;
   logic                      unused_bits;

   // Upper address bits are dropped, so accesses wrap around the array.
   assign mem_idx   = Address[MEM_ADDR_WIDTH-1:0];
   assign mem_rdata = mem[mem_idx];

`ifdef OV_TRAP_EN
   assign trap        = Ov;
   assign unused_bits = exm_memread;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         OvFlag <= 1'b0;
      end else if (!stall && Ov) begin
         OvFlag <= 1'b1;
      end
   end
`else
   assign trap        = 1'b0;
   assign OvFlag      = 1'b0;
   assign unused_bits = ^{Ov, exm_memread};
`endif

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         Address      <= '0;
         exm_store    <= '0;
         exm_reg      <= '0;
         exm_regwrite <= 1'b0;
         exm_memread  <= 1'b0;
         exm_memwrite <= 1'b0;
         exm_memtoreg <= 1'b0;
         WBData       <= '0;
         WBReg        <= '0;
         WBRegWrite   <= 1'b0;
      end else if (!stall) begin
         Address   <= ALUResult;
         exm_store <= StoreData;
         exm_reg   <= WriteReg;
         // A flush turns the incoming instruction into a bubble but still loads its data.
         if (flush) begin
            exm_regwrite <= 1'b0;
            exm_memread  <= 1'b0;
            exm_memwrite <= 1'b0;
            exm_memtoreg <= 1'b0;
         end else begin
            exm_regwrite <= RegWrite & ~trap;
            exm_memread  <= MemRead;
            exm_memwrite <= MemWrite & ~trap;
            exm_memtoreg <= MemtoReg;
         end
         WBData     <= exm_memtoreg ? mem_rdata : Address;
         WBReg      <= exm_reg;
         WBRegWrite <= exm_regwrite;
      end
   end

   // Reset wins over a store sitting in EX/MEM, so no write happens at a reset edge.
   always_ff @(posedge clk) begin
      if (rst_n && !stall && exm_memwrite) begin
         mem[mem_idx] <= exm_store;
      end
   end

   always_comb begin
      Forward_A = 2'd0;
      Forward_B = 2'd0;
      if (exm_regwrite && !exm_memtoreg && (exm_reg != '0) && (exm_reg == Rs)) begin
         Forward_A = 2'd2;
      end else if (WBRegWrite && (WBReg != '0) && (WBReg == Rs)) begin
         Forward_A = 2'd1;
      end
      if (exm_regwrite && !exm_memtoreg && (exm_reg != '0) && (exm_reg == Rt)) begin
         Forward_B = 2'd2;
      end else if (WBRegWrite && (WBReg != '0) && (WBReg == Rt)) begin
         Forward_B = 2'd1;
      end
   end

endmodule

// File: tb/tb_mem_wb_stage.sv
// tb_mem_wb_stage: directed scoreboard bench for mem_wb_stage.
// Expectations are queued with a due cycle when stimulus is applied and checked when that cycle arrives.
module tb_mem_wb_stage;

   localparam int SEL_ADDR  = 0;
   localparam int SEL_WBD   = 1;
   localparam int SEL_WBR   = 2;
   localparam int SEL_WBRW  = 3;
   localparam int SEL_FA    = 4;
   localparam int SEL_FB    = 5;
   localparam int SEL_OVF   = 6;
   localparam int SEL_MEM7  = 7;

`ifdef OV_TRAP_EN
   localparam logic TRAP = 1'b1;
`else
   localparam logic TRAP = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst_n;
   logic [7:0] ALUResult;
   logic [7:0] StoreData;
   logic [2:0] WriteReg;
   logic       Ov;
   logic       RegWrite;
   logic       MemRead;
   logic       MemWrite;
   logic       MemtoReg;
   logic [2:0] Rs;
   logic [2:0] Rt;
   logic       stall;
   logic       flush;
   logic [7:0] Address;
   logic [7:0] WBData;
   logic [2:0] WBReg;
   logic       WBRegWrite;
   logic [1:0] Forward_A;
   logic [1:0] Forward_B;
   logic       OvFlag;

   typedef struct {
      int          due;
      int          sel;
      logic [15:0] exp;
      string       tag;
   } exp_t;

   exp_t sb[$];
   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;

   mem_wb_stage #(
      .DATA_WIDTH(8),
      .REG_DIR_WIDTH(3),
      .MEM_ADDR_WIDTH(5)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .ALUResult(ALUResult),
      .StoreData(StoreData),
      .WriteReg(WriteReg),
      .Ov(Ov),
      .RegWrite(RegWrite),
      .MemRead(MemRead),
      .MemWrite(MemWrite),
      .MemtoReg(MemtoReg),
      .Rs(Rs),
      .Rt(Rt),
      .stall(stall),
      .flush(flush),
      .Address(Address),
      .WBData(WBData),
      .WBReg(WBReg),
      .WBRegWrite(WBRegWrite),
      .Forward_A(Forward_A),
      .Forward_B(Forward_B),
      .OvFlag(OvFlag)
   );

   always #5 clk = ~clk;

   function automatic logic [15:0] observe(input int sel);
      case (sel)
         SEL_ADDR: return 16'(Address);
         SEL_WBD:  return 16'(WBData);
         SEL_WBR:  return 16'(WBReg);
         SEL_WBRW: return 16'(WBRegWrite);
         SEL_FA:   return 16'(Forward_A);
         SEL_FB:   return 16'(Forward_B);
         SEL_OVF:  return 16'(OvFlag);
         SEL_MEM7: return 16'(dut.mem[7]);
         default:  return 16'hxxxx;
      endcase
   endfunction

   task automatic pushExpect(input int sel, input logic [15:0] exp, input int lat, input string tag);
      exp_t e;
      e.due = cyc + lat;
      e.sel = sel;
      e.exp = exp;
      e.tag = tag;
      sb.push_back(e);
   endtask

   task automatic checkOutput();
      int i = 0;
      logic [15:0] obs;
      while (i < sb.size()) begin
         if (sb[i].due <= cyc) begin
            obs = observe(sb[i].sel);
            checks++;
            assert (obs === sb[i].exp) else begin
               errors++;
               $error("[TB] FAIL %s: observed %0h expected %0h (cycle %0d)", sb[i].tag, obs, sb[i].exp, cyc);
            end
            sb.delete(i);
         end else begin
            i++;
         end
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      cyc++;
      checkOutput();
   endtask

   task automatic applyStimulus(input logic [7:0] alu, input logic [7:0] sd, input logic [2:0] wr,
                                input logic rw, input logic mr, input logic mw, input logic m2r,
                                input logic ov);
      ALUResult = alu;
      StoreData = sd;
      WriteReg  = wr;
      RegWrite  = rw;
      MemRead   = mr;
      MemWrite  = mw;
      MemtoReg  = m2r;
      Ov        = ov;
      step();
   endtask

   task automatic checkNow();
      #1;
      checkOutput();
   endtask

   initial begin
      rst_n = 1'b0;
      ALUResult = '0; StoreData = '0; WriteReg = '0; Ov = 1'b0;
      RegWrite = 1'b0; MemRead = 1'b0; MemWrite = 1'b0; MemtoReg = 1'b0;
      Rs = '0; Rt = '0; stall = 1'b0; flush = 1'b0;

      $display("[TB] reset");
      step();
      step();
      rst_n = 1'b1;
      pushExpect(SEL_ADDR, 16'h0, 0, "reset_addr");
      pushExpect(SEL_WBD,  16'h0, 0, "reset_wbdata");
      pushExpect(SEL_WBR,  16'h0, 0, "reset_wbreg");
      pushExpect(SEL_WBRW, 16'h0, 0, "reset_wbrw");
      pushExpect(SEL_FA,   16'h0, 0, "reset_fwda");
      pushExpect(SEL_FB,   16'h0, 0, "reset_fwdb");
      pushExpect(SEL_OVF,  16'h0, 0, "reset_ovflag");
      checkNow();

      $display("[TB] ALU pass-through");
      pushExpect(SEL_ADDR, 16'h2A, 1, "alu_addr");
      pushExpect(SEL_WBD,  16'h2A, 2, "alu_wbdata");
      pushExpect(SEL_WBR,  16'h3,  2, "alu_wbreg");
      pushExpect(SEL_WBRW, 16'h1,  2, "alu_wbrw");
      applyStimulus(8'h2A, 8'h00, 3'd3, 1, 0, 0, 0, 0);
      applyStimulus(8'h00, 8'h00, 3'd0, 0, 0, 0, 0, 0);
      applyStimulus(8'h00, 8'h00, 3'd0, 0, 0, 0, 0, 0);

      $display("[TB] store then load with address wrap");
      pushExpect(SEL_ADDR, 16'h25, 1, "store_addr");
      applyStimulus(8'h25, 8'h5C, 3'd0, 0, 0, 1, 0, 0);
      pushExpect(SEL_WBD,  16'h5C, 2, "load_wbdata");
      pushExpect(SEL_WBR,  16'h4,  2, "load_wbreg");
      pushExpect(SEL_WBRW, 16'h1,  2, "load_wbrw");
      applyStimulus(8'h05, 8'h00, 3'd4, 1, 1, 0, 1, 0);
      applyStimulus(8'h00, 8'h00, 3'd0, 0, 0, 0, 0, 0);
      applyStimulus(8'h00, 8'h00, 3'd0, 0, 0, 0, 0, 0);

      $display("[TB] forwarding back-to-back");
      applyStimulus(8'h11, 8'h00, 3'd2, 1, 0, 0, 0, 0);
      applyStimulus(8'h22, 8'h00, 3'd2, 1, 0, 0, 0, 0);
      Rs = 3'd2; Rt = 3'd2;
      pushExpect(SEL_FA, 16'h2, 0, "fwd_exmem_a");
      pushExpect(SEL_FB, 16'h2, 0, "fwd_exmem_b");
      checkNow();
      Rt = 3'd5;
      pushExpect(SEL_FA, 16'h2, 0, "fwd_indep_a");
      pushExpect(SEL_FB, 16'h0, 0, "fwd_indep_b");
      checkNow();
      Rt = 3'd2;
      pushExpect(SEL_FA,  16'h1,  1, "fwd_memwb_a");
      pushExpect(SEL_FB,  16'h1,  1, "fwd_memwb_b");
      pushExpect(SEL_WBD, 16'h22, 1, "fwd_memwb_data");
      applyStimulus(8'h00, 8'h00, 3'd0, 0, 0, 0, 0, 0);
      Rt = 3'd5;
      pushExpect(SEL_FB, 16'h0, 0, "fwd_memwb_nomatch_b");
      checkNow();
      applyStimulus(8'h00, 8'h00, 3'd0, 0, 0, 0, 0, 0);

      $display("[TB] load in EX/MEM never forwards from Address");
      applyStimulus(8'h05, 8'h00, 3'd2, 1, 1, 0, 1, 0);
      Rs = 3'd2; Rt = 3'd2;
      pushExpect(SEL_FA, 16'h0, 0, "fwd_load_exmem_a");
      pushExpect(SEL_FB, 16'h0, 0, "fwd_load_exmem_b");
      checkNow();
      pushExpect(SEL_FA,  16'h1,  1, "fwd_load_memwb_a");
      pushExpect(SEL_FB,  16'h1,  1, "fwd_load_memwb_b");
      pushExpect(SEL_WBD, 16'h5C, 1, "fwd_load_wbdata");
      applyStimulus(8'h00, 8'h00, 3'd0, 0, 0, 0, 0, 0);

      $display("[TB] register zero");
      applyStimulus(8'h33, 8'h00, 3'd0, 1, 0, 0, 0, 0);
      Rs = 3'd0; Rt = 3'd0;
      pushExpect(SEL_FA, 16'h0, 0, "r0_exmem_a");
      checkNow();
      pushExpect(SEL_FA,   16'h0,  1, "r0_memwb_a");
      pushExpect(SEL_WBR,  16'h0,  1, "r0_wbreg");
      pushExpect(SEL_WBRW, 16'h1,  1, "r0_wbrw");
      pushExpect(SEL_WBD,  16'h33, 1, "r0_wbdata");
      applyStimulus(8'h00, 8'h00, 3'd0, 0, 0, 0, 0, 0);

      $display("[TB] stall with store pending");
      applyStimulus(8'h07, 8'h11, 3'd0, 0, 0, 1, 0, 0);
      applyStimulus(8'h27, 8'hA5, 3'd0, 0, 0, 1, 0, 0);
      stall = 1'b1;
      pushExpect(SEL_ADDR, 16'h27, 1, "stall_addr1");
      pushExpect(SEL_MEM7, 16'h11, 1, "stall_mem1");
      applyStimulus(8'h40, 8'h00, 3'd1, 1, 0, 0, 0, 0);
      pushExpect(SEL_ADDR, 16'h27, 1, "stall_addr2");
      pushExpect(SEL_MEM7, 16'h11, 1, "stall_mem2");
      applyStimulus(8'h41, 8'h00, 3'd1, 1, 0, 0, 0, 0);
      stall = 1'b0;
      pushExpect(SEL_MEM7, 16'hA5, 1, "unstall_mem");
      pushExpect(SEL_WBD,  16'hA5, 2, "unstall_load_wbdata");
      pushExpect(SEL_WBR,  16'h5,  2, "unstall_load_wbreg");
      applyStimulus(8'h07, 8'h00, 3'd5, 1, 1, 0, 1, 0);
      applyStimulus(8'h00, 8'h00, 3'd0, 0, 0, 0, 0, 0);

      $display("[TB] flush suppresses store");
      applyStimulus(8'h09, 8'h3C, 3'd0, 0, 0, 1, 0, 0);
      flush = 1'b1;
      pushExpect(SEL_ADDR, 16'h09, 1, "flush_addr");
      pushExpect(SEL_WBRW, 16'h0,  2, "flush_wbrw");
      applyStimulus(8'h09, 8'h99, 3'd7, 1, 0, 1, 0, 0);
      flush = 1'b0;
      pushExpect(SEL_WBD,  16'h3C, 2, "flush_load_wbdata");
      pushExpect(SEL_WBR,  16'h6,  2, "flush_load_wbreg");
      pushExpect(SEL_WBRW, 16'h1,  2, "flush_load_wbrw");
      applyStimulus(8'h09, 8'h00, 3'd6, 1, 1, 0, 1, 0);
      applyStimulus(8'h00, 8'h00, 3'd0, 0, 0, 0, 0, 0);

      $display("[TB] reset during store");
      rst_n = 1'b0;
      applyStimulus(8'h09, 8'h77, 3'd0, 0, 0, 1, 0, 0);
      rst_n = 1'b1;
      pushExpect(SEL_ADDR, 16'h0, 0, "rst_store_addr");
      pushExpect(SEL_WBD,  16'h0, 0, "rst_store_wbdata");
      pushExpect(SEL_WBRW, 16'h0, 0, "rst_store_wbrw");
      checkNow();
      applyStimulus(8'h00, 8'h00, 3'd0, 0, 0, 0, 0, 0);
      pushExpect(SEL_WBD, 16'h3C, 2, "rst_store_load_wbdata");
      applyStimulus(8'h09, 8'h00, 3'd1, 1, 1, 0, 1, 0);
      applyStimulus(8'h00, 8'h00, 3'd0, 0, 0, 0, 0, 0);

      $display("[TB] overflow");
      pushExpect(SEL_OVF,  16'(TRAP),  1, "ov_flag_set");
      pushExpect(SEL_WBRW, 16'(!TRAP), 2, "ov_wbrw");
      pushExpect(SEL_WBR,  16'h1,      2, "ov_wbreg");
      applyStimulus(8'h44, 8'h00, 3'd1, 1, 0, 0, 0, 1);
      applyStimulus(8'h00, 8'h00, 3'd0, 0, 0, 0, 0, 0);
      applyStimulus(8'h00, 8'h00, 3'd0, 0, 0, 0, 0, 0);
      pushExpect(SEL_OVF, 16'(TRAP), 0, "ov_flag_sticky");
      checkNow();
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      pushExpect(SEL_OVF, 16'h0, 0, "ov_flag_reset");
      checkNow();

      for (int n = 0; n < 4 && sb.size() > 0; n++) begin
         step();
      end
      if (sb.size() > 0) begin
         checks++;
         errors++;
         $display("[TB] FAIL scoreboard_drain: observed %0d pending expected 0 pending", sb.size());
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
